mxint_accumulator: RTL and testbench

Accumulates a stream of `IN_DEPTH` MxInt blocks, element-wise, into one wider, un-normalized MxInt block, aligning exponents on the fly. It sits directly upstream of `mxint_cast`. It takes partial-product blocks from the linear-layer datapath and hands the cast stage a block whose mantissas carry growth bits, leaving normalization to the cast.

---
 rtl/mxint_pkg.sv | 29 ++
 rtl/mxint_align_add.sv | 61 ++++++
 rtl/mxint_accumulator.sv | 91 +++++++++
 tb/tb_mxint_accumulator.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mxint_pkg.sv
// Shared MxInt helpers.
//   acc_width()      : mantissa width needed to sum `depth` blocks of `man_w`-bit mantissas.
//   sat_ashr()       : arithmetic right shift that yields 0 / -1 once the shift reaches the
//                      operand's logical width (truncates toward -inf, no rounding).
//   EXP_DIFF_GUARD   : extra bit on top of the exponent width so the exponent difference
//                      can be held as a signed value.
package mxint_pkg;

   localparam int unsigned EXP_DIFF_GUARD = 1;

   // Wide working width for shift arithmetic. Every lane operand is sign-extended into it.
   localparam int unsigned SHIFT_W = 64;

   function automatic int unsigned acc_width(input int unsigned man_w,
                                             input int unsigned depth);
      return man_w + $clog2(depth);
   endfunction

   // `w` is the logical width of `x`. Shifting by `w` or more leaves only sign bits.
   function automatic logic signed [SHIFT_W-1:0] sat_ashr(input logic signed [SHIFT_W-1:0] x,
                                                          input int unsigned sh,
                                                          input int unsigned w);
      if (sh >= w) begin
         return x[SHIFT_W-1] ? '1 : '0;
      end
      return x >>> sh;
   endfunction

endpackage

// File: rtl/mxint_align_add.sv
// One combinational accumulator lane: aligns the running sum and an incoming mantissa to the
// larger exponent and adds them.
// Ports:
//   acc, acc_e          : current lane sum and shared running exponent
//   man_in, exp_in      : incoming signed mantissa and its block exponent
//   first               : 1 when the incoming block starts a new group (loads instead of adds)
//   acc_next, acc_e_next: updated lane sum and exponent
module mxint_align_add
   import mxint_pkg::*;
#(
   parameter int unsigned IN_MAN_WIDTH  = 8,
   parameter int unsigned IN_EXP_WIDTH  = 4,
   parameter int unsigned OUT_MAN_WIDTH = 10
) (
   input  logic signed [OUT_MAN_WIDTH-1:0] acc,
   input  logic        [IN_EXP_WIDTH-1:0]  acc_e,
   input  logic signed [IN_MAN_WIDTH-1:0]  man_in,
   input  logic        [IN_EXP_WIDTH-1:0]  exp_in,
   input  logic                            first,
   output logic signed [OUT_MAN_WIDTH-1:0] acc_next,
   output logic        [IN_EXP_WIDTH-1:0]  acc_e_next
);

   localparam int unsigned DW = IN_EXP_WIDTH + EXP_DIFF_GUARD;

   logic signed [DW-1:0]      diff;
   logic        [DW-1:0]      neg_diff;
   logic                      diff_pos;
   logic signed [SHIFT_W-1:0] acc_ext;
   logic signed [SHIFT_W-1:0] man_ext;
   logic signed [SHIFT_W-1:0] acc_sh;
   logic signed [SHIFT_W-1:0] man_sh;
   logic signed [SHIFT_W-1:0] sum;

   assign diff     = signed'({1'b0, exp_in}) - signed'({1'b0, acc_e});
   assign neg_diff = -diff;
   assign diff_pos = !diff[DW-1] && (diff != '0);

   // Size casts of signed operands sign-extend.
   assign acc_ext = SHIFT_W'(acc);
   assign man_ext = SHIFT_W'(man_in);

   // Both shift magnitudes fit in IN_EXP_WIDTH bits whenever the matching branch is taken.
   assign acc_sh = sat_ashr(acc_ext, 32'(diff[IN_EXP_WIDTH-1:0]), OUT_MAN_WIDTH);
   assign man_sh = sat_ashr(man_ext, 32'(neg_diff[IN_EXP_WIDTH-1:0]), OUT_MAN_WIDTH);

   always_comb begin
      sum        = acc_ext + man_sh;
      acc_e_next = acc_e;
      if (first) begin
         sum        = man_ext;
         acc_e_next = exp_in;
      end else if (diff_pos) begin
         sum        = acc_sh + man_ext;
         acc_e_next = exp_in;
      end
   end

   assign acc_next = sum[OUT_MAN_WIDTH-1:0];

endmodule

// File: rtl/mxint_accumulator.sv
// Sums IN_DEPTH MxInt blocks element-wise into one wider, un-normalized MxInt block, aligning
// exponents on the fly. Normalization is left to the downstream cast stage.
// Ports:
//   clk, rst                       : clock, asynchronous active-low reset
//   mdata_in, edata_in             : input block mantissas and shared exponent
//   data_in_valid, data_in_ready   : input handshake
//   mdata_out, edata_out           : accumulated block (registered)
//   data_out_valid, data_out_ready : output handshake
// IN_DEPTH must be at least 1.
module mxint_accumulator
   import mxint_pkg::*;
#(
   parameter  int unsigned IN_MAN_WIDTH  = 8,
   parameter  int unsigned IN_EXP_WIDTH  = 4,
   parameter  int unsigned BLOCK_SIZE    = 4,
   parameter  int unsigned IN_DEPTH      = 4,
   localparam int unsigned OUT_MAN_WIDTH = acc_width(IN_MAN_WIDTH, IN_DEPTH),
   localparam int unsigned OUT_EXP_WIDTH = IN_EXP_WIDTH
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic signed [IN_MAN_WIDTH-1:0]  mdata_in [BLOCK_SIZE-1:0],
   input  logic        [IN_EXP_WIDTH-1:0]  edata_in,
   input  logic                            data_in_valid,
   output logic                            data_in_ready,
   output logic signed [OUT_MAN_WIDTH-1:0] mdata_out [BLOCK_SIZE-1:0],
   output logic        [OUT_EXP_WIDTH-1:0] edata_out,
   output logic                            data_out_valid,
   input  logic                            data_out_ready
);

   localparam int unsigned CNT_W = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;

   logic        [CNT_W-1:0]         cnt;
   logic signed [OUT_MAN_WIDTH-1:0] acc      [BLOCK_SIZE-1:0];
   logic signed [OUT_MAN_WIDTH-1:0] acc_next [BLOCK_SIZE-1:0];
   logic        [IN_EXP_WIDTH-1:0]  acc_e;
   logic        [IN_EXP_WIDTH-1:0]  lane_e   [BLOCK_SIZE-1:0];
   logic                            first;
   logic                            last;
   logic                            in_fire;

   assign first         = (cnt == '0);
   assign last          = (cnt == CNT_W'(IN_DEPTH - 1));
   assign data_in_ready = !data_out_valid || data_out_ready;
   assign in_fire       = data_in_valid && data_in_ready;

   for (genvar g = 0; g < BLOCK_SIZE; g++) begin : g_lane
      mxint_align_add #(
         .IN_MAN_WIDTH  (IN_MAN_WIDTH),
         .IN_EXP_WIDTH  (IN_EXP_WIDTH),
         .OUT_MAN_WIDTH (OUT_MAN_WIDTH)
      ) u_lane (
         .acc        (acc[g]),
         .acc_e      (acc_e),
         .man_in     (mdata_in[g]),
         .exp_in     (edata_in),
         .first      (first),
         .acc_next   (acc_next[g]),
         .acc_e_next (lane_e[g])
      );
   end

   // Every lane computes the same exponent; lane 0 is the reference.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt            <= '0;
         acc_e          <= '0;
         edata_out      <= '0;
         data_out_valid <= 1'b0;
         for (int i = 0; i < BLOCK_SIZE; i++) begin
            acc[i]       <= '0;
            mdata_out[i] <= '0;
         end
      end else begin
         if (in_fire) begin
            acc   <= acc_next;
            acc_e <= lane_e[0];
            cnt   <= last ? '0 : cnt + 1'b1;
         end
         if (in_fire && last) begin
            mdata_out      <= acc_next;
            edata_out      <= lane_e[0];
            data_out_valid <= 1'b1;
         end else if (data_out_ready) begin
            data_out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mxint_accumulator.sv
module tb_mxint_accumulator;

   typedef struct {
      int m  [4][4];
      int e  [4];
      int xm [4];
      int xe;
   } vec_t;

   typedef struct {
      longint m [4];
      int     e;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Default-parameter DUT for directed tests.
   logic signed [7:0] m_in  [3:0];
   logic        [3:0] e_in;
   logic              v_in;
   logic              i_rdy;
   logic signed [9:0] m_out [3:0];
   logic        [3:0] e_out;
   logic              o_v;
   logic              o_rdy;

   mxint_accumulator dut (
      .clk            (clk),
      .rst            (rst),
      .mdata_in       (m_in),
      .edata_in       (e_in),
      .data_in_valid  (v_in),
      .data_in_ready  (i_rdy),
      .mdata_out      (m_out),
      .edata_out      (e_out),
      .data_out_valid (o_v),
      .data_out_ready (o_rdy)
   );

   // Random-stream DUTs at IN_DEPTH=1 and IN_DEPTH=5; sel picks the active one.
   logic signed [7:0]  r_m [3:0];
   logic        [3:0]  r_e;
   logic               r_valid;
   logic               r_rdy;
   logic               sel;
   logic               i1_rdy, o1_v, i5_rdy, o5_v;
   logic signed [7:0]  m1_out [3:0];
   logic signed [10:0] m5_out [3:0];
   logic        [3:0]  e1_out, e5_out;

   mxint_accumulator #(.IN_DEPTH(1)) dut1 (
      .clk            (clk),
      .rst            (rst),
      .mdata_in       (r_m),
      .edata_in       (r_e),
      .data_in_valid  (r_valid && !sel),
      .data_in_ready  (i1_rdy),
      .mdata_out      (m1_out),
      .edata_out      (e1_out),
      .data_out_valid (o1_v),
      .data_out_ready (r_rdy && !sel)
   );

   mxint_accumulator #(.IN_DEPTH(5)) dut5 (
      .clk            (clk),
      .rst            (rst),
      .mdata_in       (r_m),
      .edata_in       (r_e),
      .data_in_valid  (r_valid && sel),
      .data_in_ready  (i5_rdy),
      .mdata_out      (m5_out),
      .edata_out      (e5_out),
      .data_out_valid (o5_v),
      .data_out_ready (r_rdy && sel)
   );

   task automatic chk(input string name, input longint act, input longint req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic send(input int m [4], input int e);
      for (int i = 0; i < 4; i++) m_in[i] = 8'(m[i]);
      e_in = 4'(e);
      v_in = 1'b1;
      chk("send_in_ready", i_rdy, 1);
      @(posedge clk);
      #1;
   endtask

   function automatic longint sat(input longint x, input int s, input int w);
      if (s >= w) return (x < 0) ? -1 : 0;
      return x >>> s;
   endfunction

   vec_t   tbl [5];
   int     ones [4];
   int     fives [4];
   exp_t   q [$];
   exp_t   ex;
   longint macc [4];
   int     macc_e, mcnt, w, depth, d, ei;
   longint mi, om [4];
   logic   ov, ir;
   logic [3:0] oe;

   initial begin
      tbl[0] = '{'{'{1, 2, -3, 127}, '{1, 2, -3, 127}, '{1, 2, -3, 127}, '{1, 2, -3, 127}},
                 '{5, 5, 5, 5}, '{4, 8, -12, 508}, 5};
      tbl[1] = '{'{'{64, -64, 3, -3}, '{1, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}},
                 '{3, 5, 5, 5}, '{17, -16, 0, -1}, 5};
      tbl[2] = '{'{'{-128, -128, 127, 0}, '{-1, -1, -1, 5}, '{-1, -1, -1, 5}, '{-1, -1, -1, 5}},
                 '{15, 0, 0, 0}, '{-131, -131, 124, 0}, 15};
      tbl[3] = '{'{'{8, -8, 100, 1}, '{1, 1, -1, 0}, '{4, -4, 5, -1}, '{10, 20, 30, 40}},
                 '{2, 4, 3, 6}, '{11, 19, 36, 39}, 6};
      tbl[4] = '{'{'{-128, 127, 0, -1}, '{-128, 127, 0, -1}, '{-128, 127, 0, -1},
                   '{-128, 127, 0, -1}},
                 '{7, 7, 7, 7}, '{-512, 508, 0, -4}, 7};
      ones  = '{1, 1, 1, 1};
      fives = '{5, 5, 5, 5};

      for (int i = 0; i < 4; i++) begin
         m_in[i] = '0;
         r_m[i]  = '0;
      end
      e_in = '0; v_in = 1'b0; o_rdy = 1'b1;
      r_e = '0; r_valid = 1'b0; r_rdy = 1'b0; sel = 1'b0;

      // Reset state
      #12;
      chk("rst_valid", o_v, 0);
      chk("rst_in_ready", i_rdy, 1);
      chk("rst_e_out", e_out, 0);
      for (int i = 0; i < 4; i++) chk("rst_m_out", m_out[i], 0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Table-driven groups
      for (int k = 0; k < 5; k++) begin
         for (int b = 0; b < 4; b++) begin
            send(tbl[k].m[b], tbl[k].e[b]);
            if (b == 2) chk("early_valid", o_v, 0);
         end
         v_in = 1'b0;
         chk("grp_valid", o_v, 1);
         chk("grp_e_out", e_out, tbl[k].xe);
         for (int i = 0; i < 4; i++) chk("grp_m_out", m_out[i], tbl[k].xm[i]);
         @(posedge clk);
         #1;
         chk("grp_drained", o_v, 0);
      end

      // Backpressure: output held for 10 cycles, input blocked
      o_rdy = 1'b0;
      for (int b = 0; b < 4; b++) send(tbl[0].m[b], 5);
      for (int i = 0; i < 4; i++) m_in[i] = 8'sd1;
      e_in = 4'd0;
      v_in = 1'b1;
      for (int c = 0; c < 10; c++) begin
         chk("bp_in_ready", i_rdy, 0);
         chk("bp_valid", o_v, 1);
         chk("bp_m3_stable", m_out[3], 508);
         chk("bp_e_stable", e_out, 5);
         @(posedge clk);
         #1;
      end
      // Release with input valid: both transfer, next group starts at count 1
      o_rdy = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_release_valid", o_v, 0);
      for (int b = 0; b < 3; b++) send(ones, 0);
      v_in = 1'b0;
      chk("bp_next_valid", o_v, 1);
      chk("bp_next_e", e_out, 0);
      for (int i = 0; i < 4; i++) chk("bp_next_m", m_out[i], 4);

      // Reset mid-group discards partial sum immediately
      send(fives, 3);
      send(fives, 3);
      v_in = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      chk("midrst_valid", o_v, 0);
      chk("midrst_e", e_out, 0);
      for (int i = 0; i < 4; i++) chk("midrst_m", m_out[i], 0);
      #2;
      rst = 1'b1;
      @(posedge clk);
      #1;
      for (int b = 0; b < 4; b++) send(ones, 0);
      v_in = 1'b0;
      chk("postrst_valid", o_v, 1);
      for (int i = 0; i < 4; i++) chk("postrst_m", m_out[i], 4);
      @(posedge clk);
      #1;

      // Random streams against a golden model
      for (int s = 0; s < 2; s++) begin
         sel   = (s == 1);
         depth = sel ? 5 : 1;
         w     = sel ? 11 : 8;
         mcnt  = 0;
         q.delete();
         for (int c = 0; c < 420; c++) begin
            if (c < 400) begin
               for (int i = 0; i < 4; i++) r_m[i] = 8'($urandom_range(0, 255));
               r_e     = 4'($urandom_range(0, 15));
               r_valid = ($urandom_range(0, 9) < 7);
               r_rdy   = ($urandom_range(0, 9) < 6);
            end else begin
               r_valid = 1'b0;
               r_rdy   = 1'b1;
            end
            #1;
            if (!sel) begin
               ov = o1_v; ir = i1_rdy; oe = e1_out;
               for (int i = 0; i < 4; i++) om[i] = longint'(m1_out[i]);
            end else begin
               ov = o5_v; ir = i5_rdy; oe = e5_out;
               for (int i = 0; i < 4; i++) om[i] = longint'(m5_out[i]);
            end
            chk("rnd_in_ready_rule", ir, !ov || r_rdy);
            if (ov && r_rdy) begin
               chk("rnd_out_has_expect", q.size() > 0, 1);
               if (q.size() > 0) begin
                  ex = q.pop_front();
                  chk("rnd_e_out", oe, ex.e);
                  for (int i = 0; i < 4; i++) chk("rnd_m_out", om[i], ex.m[i]);
               end
            end
            if (r_valid && ir) begin
               ei = int'(r_e);
               if (mcnt == 0) begin
                  for (int i = 0; i < 4; i++) macc[i] = longint'(r_m[i]);
                  macc_e = ei;
               end else begin
                  d = ei - macc_e;
                  for (int i = 0; i < 4; i++) begin
                     mi = longint'(r_m[i]);
                     if (d > 0) macc[i] = sat(macc[i], d, w) + mi;
                     else       macc[i] = macc[i] + sat(mi, -d, w);
                  end
                  if (d > 0) macc_e = ei;
               end
               mcnt++;
               if (mcnt == depth) begin
                  ex.m = macc;
                  ex.e = macc_e;
                  q.push_back(ex);
                  mcnt = 0;
               end
            end
            @(posedge clk);
            #1;
         end
         chk("rnd_queue_empty", q.size(), 0);
         chk("rnd_no_extra_out", sel ? o5_v : o1_v, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
